mips_cpu_bus_arbiter: RTL

MIPS_CPU_BUS_ARBITER -- requirements
Module: mips_cpu_bus_arbiter

---
 rtl/mips_cpu_bus_arbiter.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/mips_cpu_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mips_cpu_bus_arbiter
// Description : Two-master arbiter that shares one Avalon-style memory bus
//               between a read-only instruction-fetch port and a read/write
//               data port. Ties are broken round-robin and back-to-back
//               transactions need no idle cycles. A sticky error flag is set
//               when one grant stalls for too long.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_cpu_bus_arbiter #(
    parameter int unsigned WAIT_LIMIT = 1024
) (
    input  logic        clk,
    input  logic        reset,

    // instruction-fetch port (read only)
    input  logic [31:0] i_address,
    input  logic        i_read,
    output logic        i_waitrequest,
    output logic [31:0] i_readdata,

    // data port
    input  logic [31:0] d_address,
    input  logic [31:0] d_writedata,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [3:0]  d_byteenable,
    output logic        d_waitrequest,
    output logic [31:0] d_readdata,

    // shared memory bus
    output logic [31:0] m_address,
    output logic [31:0] m_writedata,
    output logic        m_read,
    output logic        m_write,
    output logic [3:0]  m_byteenable,
    input  logic        m_waitrequest,
    input  logic [31:0] m_readdata,

    // status
    output logic [1:0]  grant,
    output logic        timeout_err
);

    // The counter must be able to hold WAIT_LIMIT itself, where it saturates.
    localparam int unsigned      CNT_W     = $clog2(WAIT_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(WAIT_LIMIT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // Identity of the port that completed the most recent transaction.
    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_DATA  = 1'b1;

    localparam logic [1:0] GRANT_NONE  = 2'b00;
    localparam logic [1:0] GRANT_FETCH = 2'b01;
    localparam logic [1:0] GRANT_DATA  = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [1:0]       grant_next;
    logic             last_served;
    logic             last_served_next;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_next;

    logic             req_fetch;
    logic             req_data;
    logic             owner_req;
    logic             complete;
    logic             dropped;

    // Pick the next owner from the two requests; on a tie the port that was
    // not served last wins.
    function automatic state_t arbitrate(input logic rf, input logic rd,
                                         input logic ls);
        state_t pick;
        pick = IDLE;
        if (rf && rd) begin
            pick = (ls == PORT_DATA) ? GNT_I : GNT_D;
        end else if (rf) begin
            pick = GNT_I;
        end else if (rd) begin
            pick = GNT_D;
        end
        return pick;
    endfunction

    assign req_fetch = i_read;
    assign req_data  = d_read | d_write;

    // Request level of whichever port currently owns the bus.
    always_comb begin
        owner_req = 1'b0;
        case (state)
            GNT_I:   owner_req = req_fetch;
            GNT_D:   owner_req = req_data;
            default: owner_req = 1'b0;
        endcase
    end

    // A transfer completes when the owner is still requesting and memory
    // does not stall; an owner that withdraws its request just gives up.
    assign complete = (state != IDLE) &&  owner_req && !m_waitrequest;
    assign dropped  = (state != IDLE) && !owner_req;

    // Round-robin history advances only on a real completion.
    always_comb begin
        last_served_next = last_served;
        if (complete) begin
            last_served_next = (state == GNT_D) ? PORT_DATA : PORT_FETCH;
        end
    end

    // Next owner: a completion re-arbitrates on the same edge so that
    // transfers can run back to back; a stalled owner is never preempted.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                state_next = arbitrate(req_fetch, req_data, last_served);
            end
            GNT_I, GNT_D: begin
                if (dropped) begin
                    state_next = IDLE;
                end else if (complete) begin
                    state_next = arbitrate(req_fetch, req_data, last_served_next);
                end else begin
                    state_next = state;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // One-hot owner indication, registered together with the state.
    always_comb begin
        grant_next = GRANT_NONE;
        case (state_next)
            GNT_I:   grant_next = GRANT_FETCH;
            GNT_D:   grant_next = GRANT_DATA;
            default: grant_next = GRANT_NONE;
        endcase
    end

    // Count consecutive stalled cycles of the current grant, saturating at
    // the limit; any non-stalled or idle cycle restarts the count.
    always_comb begin
        wait_cnt_next = '0;
        if ((state != IDLE) && m_waitrequest) begin
            wait_cnt_next = (wait_cnt == CNT_LIMIT) ? wait_cnt : (wait_cnt + CNT_ONE);
        end
    end

    // Arbiter state, grant, round-robin history, stall counter and sticky error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            grant       <= GRANT_NONE;
            last_served <= PORT_DATA;
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_next;
            grant       <= grant_next;
            last_served <= last_served_next;
            wait_cnt    <= wait_cnt_next;
            timeout_err <= timeout_err | (wait_cnt_next == CNT_LIMIT);
        end
    end

    // Memory bus steering: fetch is forced to a full-word read, data is
    // forwarded untouched (even a simultaneous read and write), idle is quiet.
    always_comb begin
        m_address    = 32'h0000_0000;
        m_writedata  = 32'h0000_0000;
        m_read       = 1'b0;
        m_write      = 1'b0;
        m_byteenable = 4'b0000;
        case (state)
            GNT_I: begin
                m_address    = i_address;
                m_read       = i_read;
                m_byteenable = 4'b1111;
            end
            GNT_D: begin
                m_address    = d_address;
                m_writedata  = d_writedata;
                m_read       = d_read;
                m_write      = d_write;
                m_byteenable = d_byteenable;
            end
            default: begin
                m_address    = 32'h0000_0000;
            end
        endcase
    end

    // Only the owning port is released, and only when memory is ready.
    assign i_waitrequest = !((state == GNT_I) && !m_waitrequest);
    assign d_waitrequest = !((state == GNT_D) && !m_waitrequest);

    // Read data is shared; each port only looks at it in its completion cycle.
    assign i_readdata = m_readdata;
    assign d_readdata = m_readdata;

endmodule
`default_nettype wire
